load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the pipeline MEM stage and the byte-addressed data memory (DataMem).
- Accepts one RV32I load/store request at a time and sequences the memory's memR/memW strobes.
- Performs sub-word stores as read-modify-write, so neighbouring bytes are never clobbered.
- Returns sign- or zero-extended load data, and reports misaligned or out-of-range accesses as errors without touching memory.

Parameters:
- SIZE, 12, memory address width in bits. Memory holds 2**SIZE bytes; must match the DataMem instance.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU idle and able to accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3. Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Stores: SB=000, SH=001, SW=010.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  output  1  single-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  access fault, valid only with resp_valid.
- mem_addr  output  SIZE  connects to DataMem addr.
- mem_dataW  output  32  connects to DataMem dataW.
- mem_dataR  input  32  connects to DataMem dataR; byte at mem_addr is in bits [7:0].
- mem_memR  output  1  connects to DataMem memR.
- mem_memW  output  1  connects to DataMem memW.

Behaviour:
- Reset (async): state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_memR=0, mem_memW=0; mem_addr=0, mem_dataW=0.
- Handshake:
  - Request accepted on a rising edge where req_valid && req_ready; addr, funct3, we and wdata are latched at acceptance.
  - req_ready=1 only in IDLE. req_valid is ignored in every other state.
  - No response backpressure: resp_valid pulses for exactly one cycle in RESP.
- Fault check (at acceptance):
  - Misaligned: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0.
  - Out of range: addr[31:SIZE]!=0, or addr > 2**SIZE-4 (the memory always accesses 4 bytes).
  - Any funct3 not listed above is also a fault.
  - On fault: go directly to RESP with resp_err=1; mem_memR and mem_memW stay 0.
- States:
  - IDLE: memR=0. Legal load -> RD. Legal SW -> WR. Legal SB/SH -> RD with RMW flag set.
  - RD: memR=1, mem_addr=latched addr[SIZE-1:0]; next state CAP.
  - CAP: memR still 1; capture mem_dataR into an internal register. Load -> RESP. RMW -> WR.
  - WR: memW=1 for exactly one cycle.
    - SW: mem_dataW = req_wdata.
    - SB: mem_dataW = {captured[31:8], wdata[7:0]}.
    - SH: mem_dataW = {captured[31:16], wdata[15:0]}.
    - Next state RESP.
  - RESP: resp_valid=1; memR=0, memW=0; next state IDLE.
- memR must return to 0 between consecutive reads, because the memory responds only to memR edges. The IDLE and RESP states guarantee this.
- Latency from acceptance edge to resp_valid: load 3 cycles; SW 2; SB/SH 4; fault 1.
- Load extension:
  - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
  - LW: pass [31:0] through.
- Reset mid-operation: FSM returns to IDLE immediately and memW drops asynchronously. A store either completes fully on an edge where memW is sampled high or does not occur; no partial RMW byte merge is ever written. No response is issued for an aborted request.
- Back-to-back requests: a new request can be accepted the cycle after RESP.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum lsu_state_t {IDLE, RD, CAP, WR, RESP};
  - the function is_misaligned(funct3, addr[1:0]).
- One combinational sub-module, lsu_align, performs load extension and store byte/halfword merge from (funct3, captured word, wdata). The FSM stays in load_store_unit.

Test Plan:
- SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> memW pulses once; the LW response 3 cycles after acceptance returns rdata=0xDEADBEEF, err=0.
- After the above, SB addr 0x011 data 0x000000AA, then LW 0x010 -> 0xDEADAAEF (neighbour bytes preserved); SB response 4 cycles after acceptance.
- Word 0x00008081 at 0x020:
  - LB 0x020 -> 0xFFFFFF81.
  - LBU 0x020 -> 0x00000081.
  - LH 0x020 -> 0xFFFF8081.
  - LHU 0x020 -> 0x00008081.
- LW 0x013, SH 0x021, and LW 0x1000 (SIZE=12) -> each gives resp_err=1 one cycle after acceptance; memR and memW are never asserted; memory contents unchanged.
- Back-to-back LW 0x010 then LW 0x020 with req_valid held high -> memR drops to 0 between the two accesses; both return correct data; req_ready is low throughout each operation.
- Assert rst during WR of an SB -> resp_valid is never asserted; memR=memW=0 immediately; the target word holds either the fully merged value or the original value; the next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, the
// sequencing FSM state type and the alignment check helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} lsu_state_t;

   // Halfwords need an even address, words a multiple of four; bytes are
   // always aligned. Unknown funct3 codes are rejected elsewhere.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      logic mis;
      case (funct3)
         F3_H, F3_HU: mis = addr_lo[0];
         F3_W:        mis = (addr_lo != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
//   funct3     : access type of the request in flight
//   word       : 32-bit word read from memory (byte at the address in [7:0])
//   wdata      : store data from the request
//   load_data  : sign/zero-extended load result
//   store_data : word to write back (sub-word stores merged into word)
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   always_comb begin
      case (funct3)
         F3_B:    load_data = {{24{word[7]}}, word[7:0]};
         F3_H:    load_data = {{16{word[15]}}, word[15:0]};
         F3_BU:   load_data = {24'h0, word[7:0]};
         F3_HU:   load_data = {16'h0, word[15:0]};
         default: load_data = word;
      endcase
   end

   // The memory always writes four bytes, so the untouched upper bytes are
   // rewritten with the values just read.
   always_comb begin
      case (funct3)
         F3_B:    store_data = {word[31:8], wdata[7:0]};
         F3_H:    store_data = {word[31:16], wdata[15:0]};
         default: store_data = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a byte-addressed DataMem.
// Handles one request at a time, sequences memR/memW, performs sub-word
// stores as read-modify-write and flags misaligned/out-of-range accesses.
//   clk, rst                : clock, asynchronous active-high reset
//   req_*                   : request handshake (valid/ready) and payload
//   resp_valid/rdata/err    : one-cycle completion pulse with load data
//   mem_addr/dataW/dataR    : DataMem address and data buses
//   mem_memR/memW           : DataMem read/write strobes
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int SIZE = 12
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [31:0]     req_addr,
   input  logic [31:0]     req_wdata,
   output logic            resp_valid,
   output logic [31:0]     resp_rdata,
   output logic            resp_err,
   output logic [SIZE-1:0] mem_addr,
   output logic [31:0]     mem_dataW,
   input  logic [31:0]     mem_dataR,
   output logic            mem_memR,
   output logic            mem_memW
);

   // Highest legal start address: the memory always touches four bytes.
   localparam logic [SIZE-1:0] LAST_WORD = {SIZE{1'b1}} - SIZE'(3);

   lsu_state_t  state;
   logic [2:0]  f3_q;
   logic        we_q;
   logic [31:0] wdata_q;

   logic        f3_legal;
   logic        out_of_range;
   logic        fault;
   logic [31:0] load_data;
   logic [31:0] store_data;

   always_comb begin
      if (req_we) f3_legal = req_funct3 inside {F3_B, F3_H, F3_W};
      else        f3_legal = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      out_of_range = (req_addr[31:SIZE] != '0) || (req_addr[SIZE-1:0] > LAST_WORD);
      fault = !f3_legal || out_of_range || is_misaligned(req_funct3, req_addr[1:0]);
   end

   // mem_dataR is stable during CAP, which is the only cycle the aligned
   // results are consumed, so the word feeds the aligner directly.
   lsu_align u_align (
      .funct3     (f3_q),
      .word       (mem_dataR),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_memR   <= 1'b0;
         mem_memW   <= 1'b0;
         mem_addr   <= '0;
         mem_dataW  <= '0;
         f3_q       <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  f3_q       <= req_funct3;
                  we_q       <= req_we;
                  wdata_q    <= req_wdata;
                  req_ready  <= 1'b0;
                  resp_rdata <= '0;
                  if (fault) begin
                     // Faults never touch memory.
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     mem_addr <= req_addr[SIZE-1:0];
                     if (req_we && req_funct3 == F3_W) begin
                        state     <= WR;
                        mem_memW  <= 1'b1;
                        mem_dataW <= req_wdata;
                     end else begin
                        // Loads and sub-word stores both start with a read.
                        state    <= RD;
                        mem_memR <= 1'b1;
                     end
                  end
               end
            end
            RD: state <= CAP;
            CAP: begin
               mem_memR <= 1'b0;
               if (we_q) begin
                  state     <= WR;
                  mem_memW  <= 1'b1;
                  mem_dataW <= store_data;
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= load_data;
               end
            end
            WR: begin
               mem_memW   <= 1'b0;
               state      <= RESP;
               resp_valid <= 1'b1;
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
